// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the parametrised 2-read/1-write register file.
// Entry data types are declared per module from DATA_WIDTH; ZERO_DATA covers widths up to 64.
package regfile_pkg;

   localparam int unsigned MAX_DATA_WIDTH = 64;

   typedef logic [MAX_DATA_WIDTH-1:0] max_data_t;

   localparam max_data_t ZERO_DATA = '0;

   // Address width for a given entry count; never below one bit.
   function automatic int unsigned calc_aw(input int unsigned n);
      return (n < 2) ? 1 : int'($clog2(n));
   endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: entry/valid mux, optional write bypass and
// optional hardwired-zero entry 0.
module regfile_read_port
   import regfile_pkg::*;
#(
   parameter int unsigned NUM_ENTRIES = 4,
   parameter int unsigned DATA_WIDTH  = 4,
   parameter int unsigned BYPASS      = 0,
   parameter int unsigned ZERO_REG0   = 0,
   parameter int unsigned AW          = 2
) (
   input  logic [NUM_ENTRIES-1:0][DATA_WIDTH-1:0] mem,
   input  logic [NUM_ENTRIES-1:0]                 valid,
   input  logic                                   wen,
   input  logic [AW-1:0]                          waddr,
   input  logic [DATA_WIDTH-1:0]                  wdata,
   input  logic [AW-1:0]                          raddr,
   output logic [DATA_WIDTH-1:0]                  rdata,
   output logic                                   rvalid
);

   typedef logic [DATA_WIDTH-1:0] data_t;

   always_comb begin
      rdata  = data_t'(mem[raddr]);
      rvalid = valid[raddr];
      if (BYPASS != 0 && wen && (waddr == raddr)) begin
         rdata  = wdata;
         rvalid = 1'b1;
      end
      // Applied last so entry 0 is never forwarded from a write.
      if (ZERO_REG0 != 0 && raddr == '0) begin
         rdata  = ZERO_DATA[DATA_WIDTH-1:0];
         rvalid = 1'b1;
      end
   end

endmodule

// File: rtl/regfile_2r1w_param.sv
// Parametrised register file: storage, valid tracking, write/clear/reset,
// and two independent combinational read ports.
module regfile_2r1w_param
   import regfile_pkg::*;
#(
   parameter int unsigned NUM_ENTRIES = 4,
   parameter int unsigned DATA_WIDTH  = 4,
   parameter int unsigned BYPASS      = 0,
   parameter int unsigned ZERO_REG0   = 0,
   localparam int unsigned AW         = calc_aw(NUM_ENTRIES)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  wen,
   input  logic [AW-1:0]         waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [AW-1:0]         raddr0,
   output logic [DATA_WIDTH-1:0] rdata0,
   output logic                  rvalid0,
   input  logic [AW-1:0]         raddr1,
   output logic [DATA_WIDTH-1:0] rdata1,
   output logic                  rvalid1
);

   logic [NUM_ENTRIES-1:0][DATA_WIDTH-1:0] mem_q, mem_d;
   logic [NUM_ENTRIES-1:0]                 valid_q, valid_d;
   logic                                   wr_ok;

   assign wr_ok = wen && !(ZERO_REG0 != 0 && waddr == '0);

   // Write lands on top of a same-cycle clear.
   always_comb begin
      mem_d   = mem_q;
      valid_d = valid_q;
      if (clear) begin
         mem_d   = '0;
         valid_d = '0;
      end
      if (wr_ok) begin
         mem_d[waddr]   = wdata;
         valid_d[waddr] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_q   <= '0;
         valid_q <= '0;
      end else begin
         mem_q   <= mem_d;
         valid_q <= valid_d;
      end
   end

   regfile_read_port #(
      .NUM_ENTRIES (NUM_ENTRIES),
      .DATA_WIDTH  (DATA_WIDTH),
      .BYPASS      (BYPASS),
      .ZERO_REG0   (ZERO_REG0),
      .AW          (AW)
   ) u_rd0 (
      .mem    (mem_q),
      .valid  (valid_q),
      .wen    (wen),
      .waddr  (waddr),
      .wdata  (wdata),
      .raddr  (raddr0),
      .rdata  (rdata0),
      .rvalid (rvalid0)
   );

   regfile_read_port #(
      .NUM_ENTRIES (NUM_ENTRIES),
      .DATA_WIDTH  (DATA_WIDTH),
      .BYPASS      (BYPASS),
      .ZERO_REG0   (ZERO_REG0),
      .AW          (AW)
   ) u_rd1 (
      .mem    (mem_q),
      .valid  (valid_q),
      .wen    (wen),
      .waddr  (waddr),
      .wdata  (wdata),
      .raddr  (raddr1),
      .rdata  (rdata1),
      .rvalid (rvalid1)
   );

endmodule

// File: tb/tb_regfile_2r1w_param.sv
// Directed bench: three 4x4 variants share one stimulus bus, plus a 32x32 instance.
module tb_regfile_2r1w_param;

   logic       clk;
   logic       rst;
   logic       clear, wen;
   logic [1:0] waddr, raddr0, raddr1;
   logic [3:0] wdata;

   logic [3:0] b_rd0, b_rd1, y_rd0, y_rd1, z_rd0, z_rd1;
   logic       b_rv0, b_rv1, y_rv0, y_rv1, z_rv0, z_rv1;

   logic        w_clear, w_wen;
   logic [4:0]  w_waddr, w_raddr0, w_raddr1;
   logic [31:0] w_wdata, w_rd0, w_rd1;
   logic        w_rv0, w_rv1;

   int checks;
   int failures;

   typedef struct packed {
      logic       clr;
      logic       we;
      logic [1:0] wa;
      logic [3:0] wd;
      logic [1:0] ra0;
      logic [1:0] ra1;
      logic [3:0] rd0;
      logic       rv0;
      logic [3:0] rd1;
      logic       rv1;
   } vec_t;

   vec_t vecs [16];

   regfile_2r1w_param #(.NUM_ENTRIES(4), .DATA_WIDTH(4), .BYPASS(0), .ZERO_REG0(0)) u_base (
      .clk(clk), .rst(rst), .clear(clear), .wen(wen), .waddr(waddr), .wdata(wdata),
      .raddr0(raddr0), .rdata0(b_rd0), .rvalid0(b_rv0),
      .raddr1(raddr1), .rdata1(b_rd1), .rvalid1(b_rv1)
   );

   regfile_2r1w_param #(.NUM_ENTRIES(4), .DATA_WIDTH(4), .BYPASS(1), .ZERO_REG0(0)) u_byp (
      .clk(clk), .rst(rst), .clear(clear), .wen(wen), .waddr(waddr), .wdata(wdata),
      .raddr0(raddr0), .rdata0(y_rd0), .rvalid0(y_rv0),
      .raddr1(raddr1), .rdata1(y_rd1), .rvalid1(y_rv1)
   );

   regfile_2r1w_param #(.NUM_ENTRIES(4), .DATA_WIDTH(4), .BYPASS(1), .ZERO_REG0(1)) u_zero (
      .clk(clk), .rst(rst), .clear(clear), .wen(wen), .waddr(waddr), .wdata(wdata),
      .raddr0(raddr0), .rdata0(z_rd0), .rvalid0(z_rv0),
      .raddr1(raddr1), .rdata1(z_rd1), .rvalid1(z_rv1)
   );

   regfile_2r1w_param #(.NUM_ENTRIES(32), .DATA_WIDTH(32), .BYPASS(0), .ZERO_REG0(0)) u_wide (
      .clk(clk), .rst(rst), .clear(w_clear), .wen(w_wen), .waddr(w_waddr), .wdata(w_wdata),
      .raddr0(w_raddr0), .rdata0(w_rd0), .rvalid0(w_rv0),
      .raddr1(w_raddr1), .rdata1(w_rd1), .rvalid1(w_rv1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic c, input logic we, input logic [1:0] wa, input logic [3:0] wd,
                        input logic [1:0] ra0, input logic [1:0] ra1);
      clear  = c;
      wen    = we;
      waddr  = wa;
      wdata  = wd;
      raddr0 = ra0;
      raddr1 = ra1;
   endtask

   initial begin
      logic [31:0] exp0, exp1;
      checks   = 0;
      failures = 0;

      //             clr   we    wa    wd    ra0   ra1   rd0   rv0   rd1   rv1
      vecs[0]  = '{1'b0, 1'b0, 2'd0, 4'h0, 2'd0, 2'd1, 4'h0, 1'b0, 4'h0, 1'b0};
      vecs[1]  = '{1'b0, 1'b1, 2'd1, 4'h5, 2'd1, 2'd3, 4'h0, 1'b0, 4'h0, 1'b0};
      vecs[2]  = '{1'b0, 1'b1, 2'd3, 4'hC, 2'd1, 2'd3, 4'h5, 1'b1, 4'h0, 1'b0};
      vecs[3]  = '{1'b0, 1'b0, 2'd0, 4'h0, 2'd1, 2'd3, 4'h5, 1'b1, 4'hC, 1'b1};
      vecs[4]  = '{1'b0, 1'b0, 2'd0, 4'h0, 2'd3, 2'd3, 4'hC, 1'b1, 4'hC, 1'b1};
      vecs[5]  = '{1'b0, 1'b1, 2'd0, 4'h1, 2'd0, 2'd2, 4'h0, 1'b0, 4'h0, 1'b0};
      vecs[6]  = '{1'b0, 1'b1, 2'd2, 4'h3, 2'd0, 2'd2, 4'h1, 1'b1, 4'h0, 1'b0};
      vecs[7]  = '{1'b0, 1'b1, 2'd2, 4'h9, 2'd2, 2'd1, 4'h3, 1'b1, 4'h5, 1'b1};
      vecs[8]  = '{1'b0, 1'b1, 2'd1, 4'h2, 2'd2, 2'd1, 4'h9, 1'b1, 4'h5, 1'b1};
      vecs[9]  = '{1'b0, 1'b1, 2'd2, 4'h3, 2'd1, 2'd2, 4'h2, 1'b1, 4'h9, 1'b1};
      vecs[10] = '{1'b0, 1'b1, 2'd3, 4'h4, 2'd2, 2'd3, 4'h3, 1'b1, 4'hC, 1'b1};
      vecs[11] = '{1'b1, 1'b1, 2'd1, 4'hF, 2'd3, 2'd0, 4'h4, 1'b1, 4'h1, 1'b1};
      vecs[12] = '{1'b0, 1'b0, 2'd0, 4'h0, 2'd1, 2'd0, 4'hF, 1'b1, 4'h0, 1'b0};
      vecs[13] = '{1'b0, 1'b0, 2'd0, 4'h0, 2'd2, 2'd3, 4'h0, 1'b0, 4'h0, 1'b0};
      vecs[14] = '{1'b1, 1'b0, 2'd0, 4'h0, 2'd1, 2'd1, 4'hF, 1'b1, 4'hF, 1'b1};
      vecs[15] = '{1'b0, 1'b0, 2'd0, 4'h0, 2'd1, 2'd0, 4'h0, 1'b0, 4'h0, 1'b0};

      rst      = 1'b0;
      drive(1'b0, 1'b0, 2'd0, 4'h0, 2'd0, 2'd0);
      w_clear  = 1'b0;
      w_wen    = 1'b0;
      w_waddr  = '0;
      w_wdata  = '0;
      w_raddr0 = '0;
      w_raddr1 = '0;
      #12 rst = 1'b1;
      step();

      // Reset state on every address, including the hardwired entry 0.
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, 2'd0, 4'h0, 2'(i), 2'(i));
         #1;
         check($sformatf("rst_rd0[%0d]", i), 32'(b_rd0), 32'h0);
         check($sformatf("rst_rv1[%0d]", i), 32'(b_rv1), 32'h0);
         check($sformatf("rst_zero_rv0[%0d]", i), 32'(z_rv0), (i == 0) ? 32'h1 : 32'h0);
         step();
      end

      // Async reset mid-cycle wipes a written entry with no clock edge.
      drive(1'b0, 1'b1, 2'd2, 4'hA, 2'd0, 2'd0);
      step();
      drive(1'b0, 1'b0, 2'd0, 4'h0, 2'd2, 2'd0);
      #1;
      check("pre_rst_rd0", 32'(b_rd0), 32'hA);
      check("pre_rst_rv0", 32'(b_rv0), 32'h1);
      #2 rst = 1'b0;
      #1;
      check("async_rst_rd0", 32'(b_rd0), 32'h0);
      check("async_rst_rv0", 32'(b_rv0), 32'h0);
      check("async_rst_zero_rv1", 32'(z_rv1), 32'h1);
      check("async_rst_zero_rd1", 32'(z_rd1), 32'h0);
      #1 rst = 1'b1;
      step();
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, 2'd0, 4'h0, 2'(i), 2'(3 - i));
         #1;
         check($sformatf("post_rst_rd0[%0d]", i), 32'(b_rd0), 32'h0);
         check($sformatf("post_rst_rv0[%0d]", i), 32'(b_rv0), 32'h0);
         check($sformatf("post_rst_rv1[%0d]", i), 32'(b_rv1), 32'h0);
         step();
      end

      // Table: write/read, BYPASS=0 timing, clear+write, clear alone.
      for (int i = 0; i < 16; i++) begin
         drive(vecs[i].clr, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra0, vecs[i].ra1);
         #1;
         check($sformatf("vec%0d_rd0", i), 32'(b_rd0), 32'(vecs[i].rd0));
         check($sformatf("vec%0d_rv0", i), 32'(b_rv0), 32'(vecs[i].rv0));
         check($sformatf("vec%0d_rd1", i), 32'(b_rd1), 32'(vecs[i].rd1));
         check($sformatf("vec%0d_rv1", i), 32'(b_rv1), 32'(vecs[i].rv1));
         step();
      end

      // Bypass: entry 1=6, entry 2=3, then overwrite entry 2 while reading it.
      drive(1'b0, 1'b1, 2'd1, 4'h6, 2'd0, 2'd0);
      step();
      drive(1'b0, 1'b1, 2'd2, 4'h3, 2'd0, 2'd0);
      step();
      drive(1'b0, 1'b1, 2'd2, 4'h9, 2'd2, 2'd1);
      #1;
      check("byp_rd0", 32'(y_rd0), 32'h9);
      check("byp_rv0", 32'(y_rv0), 32'h1);
      check("byp_rd1_other", 32'(y_rd1), 32'h6);
      check("nobyp_rd0", 32'(b_rd0), 32'h3);
      step();
      drive(1'b0, 1'b0, 2'd0, 4'h0, 2'd2, 2'd1);
      #1;
      check("nobyp_next_rd0", 32'(b_rd0), 32'h9);
      check("byp_next_rd0", 32'(y_rd0), 32'h9);
      step();

      // Bypass still forwards during a same-cycle clear; entry 3 was cleared earlier.
      drive(1'b1, 1'b1, 2'd3, 4'hA, 2'd3, 2'd2);
      #1;
      check("byp_clr_rd0", 32'(y_rd0), 32'hA);
      check("byp_clr_rv0", 32'(y_rv0), 32'h1);
      check("byp_clr_rd1", 32'(y_rd1), 32'h9);
      check("nobyp_clr_rv0", 32'(b_rv0), 32'h0);
      step();
      drive(1'b0, 1'b0, 2'd0, 4'h0, 2'd3, 2'd2);
      #1;
      check("after_clr_rd0", 32'(y_rd0), 32'hA);
      check("after_clr_rv0", 32'(y_rv0), 32'h1);
      check("after_clr_rd1", 32'(y_rd1), 32'h0);
      check("after_clr_rv1", 32'(y_rv1), 32'h0);
      step();

      // Hardwired entry 0: write dropped and never bypassed.
      drive(1'b0, 1'b1, 2'd0, 4'h7, 2'd0, 2'd0);
      #1;
      check("zero_same_rd0", 32'(z_rd0), 32'h0);
      check("zero_same_rv0", 32'(z_rv0), 32'h1);
      check("zero_same_rd1", 32'(z_rd1), 32'h0);
      check("byp_entry0_rd0", 32'(y_rd0), 32'h7);
      step();
      drive(1'b0, 1'b0, 2'd0, 4'h0, 2'd0, 2'd3);
      #1;
      check("zero_next_rd0", 32'(z_rd0), 32'h0);
      check("zero_next_rv0", 32'(z_rv0), 32'h1);
      check("zero_other_rd1", 32'(z_rd1), 32'hA);
      check("byp_entry0_next", 32'(y_rd0), 32'h7);
      step();

      // Wide config: fill with addr*0x01010101 and read back on both ports.
      for (int i = 0; i < 32; i++) begin
         w_wen   = 1'b1;
         w_waddr = 5'(i);
         w_wdata = i * 32'h01010101;
         step();
      end
      w_wen = 1'b0;
      for (int i = 0; i < 32; i++) begin
         w_raddr0 = 5'(i);
         w_raddr1 = 5'(31 - i);
         #1;
         exp0 = i * 32'h01010101;
         exp1 = (31 - i) * 32'h01010101;
         check($sformatf("wide_rd0[%0d]", i), w_rd0, exp0);
         check($sformatf("wide_rd1[%0d]", 31 - i), w_rd1, exp1);
         check($sformatf("wide_rv0[%0d]", i), 32'(w_rv0), 32'h1);
         step();
      end
      w_wen   = 1'b1;
      w_waddr = 5'd31;
      w_wdata = 32'hDEADBEEF;
      step();
      w_wen = 1'b0;
      for (int i = 0; i < 32; i++) begin
         w_raddr0 = 5'(i);
         w_raddr1 = 5'd31;
         #1;
         exp0 = (i == 31) ? 32'hDEADBEEF : i * 32'h01010101;
         check($sformatf("wide_top_rd0[%0d]", i), w_rd0, exp0);
         check("wide_top_rd1", w_rd1, 32'hDEADBEEF);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/regfile_2r1w_param.md
Name: regfile_2r1w_param

Overview:
- Parametrised register file: two combinational read ports, one clocked write port, per-entry valid tracking.
- Next generation of the flat 1r1w 4x4b regfile. Generalised in depth and width.
- Adds a second read port, optional write-to-read bypass, optional hardwired-zero entry 0, and a synchronous bulk clear.
- Sits in the datapath as the architectural register store feeding the two ALU operands.

Parameters:
- NUM_ENTRIES, 4: number of entries; power of two, >= 2.
- DATA_WIDTH, 4: bits per entry, >= 1.
- BYPASS, 0: 1 = a same-cycle write is forwarded to a matching read port.
- ZERO_REG0, 0: 1 = entry 0 reads as 0, ignores writes, and is always valid.
- Derived: AW = $clog2(NUM_ENTRIES).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous bulk clear of all data and valid bits.
- wen  in  1  write enable.
- waddr  in  AW  write address.
- wdata  in  DATA_WIDTH  write data.
- raddr0  in  AW  read port 0 address.
- rdata0  out  DATA_WIDTH  read port 0 data.
- rvalid0  out  1  entry at raddr0 has been written since the last reset/clear.
- raddr1  in  AW  read port 1 address.
- rdata1  out  DATA_WIDTH  read port 1 data.
- rvalid1  out  1  as rvalid0, for port 1.

Behaviour:
- Reset:
  - rst low immediately (no clock needed) forces every entry to 0 and every valid bit to 0.
  - Outputs therefore read rdataN=0. rvalidN=0, except rvalidN=1 for address 0 when ZERO_REG0=1.
  - rst deasserted mid-cycle: state holds until the next rising edge.
- Write:
  - On posedge, if wen: entry[waddr] <= wdata and valid[waddr] <= 1.
  - Write latency: 1 cycle. The value is visible on a non-bypass read in the cycle after the edge.
- Read:
  - Purely combinational from raddrN.
  - Both ports are independent; the same address may be read on both ports in the same cycle.
- Bypass:
  - Applies when BYPASS=1 and wen && waddr==raddrN (and not the zero-entry case).
  - Then rdataN = wdata and rvalidN = 1 in the same cycle.
  - BYPASS=0: reads return the pre-edge stored value.
- Clear:
  - On posedge, if clear: all entries <= 0 and all valid <= 0.
  - If wen is also asserted in that cycle, the write is applied after the clear: entry[waddr]=wdata and valid[waddr]=1; all other entries are 0.
  - Bypass is unaffected by clear in the same cycle; it still forwards wdata.
- ZERO_REG0=1:
  - Writes with waddr=0 are dropped and never bypassed.
  - raddrN=0 always returns rdataN=0, rvalidN=1.
- Address range: full AW range is legal. No wrap or out-of-range case exists because NUM_ENTRIES=2^AW.
- No X propagation: uninitialised entries read 0 after reset.
- Precedence per entry on posedge: rst (async) > wen > clear > hold.

Decomposition:
- Package regfile_pkg holds:
  - the localparam AW helper function (clog2 wrapper);
  - the typedef for the entry data type, parametrised via module-level typedef;
  - the constant ZERO_DATA.
- One natural sub-module, regfile_read_port, instantiated twice. It contains:
  - the address mux over the entry array and valid array;
  - the bypass compare/select;
  - the zero-entry override.
- The top level owns the storage array, valid bits, and write/clear/reset logic.

Test Plan:
1. Reset: drive rst=0 mid-cycle after writing entry 2=0xA, no clock edge. Required: rdata0(raddr0=2)=0 and rvalid0=0 immediately. After release, all entries read 0/invalid.
2. Basic 2R: write 1=0x5, then 3=0xC. Read raddr0=1, raddr1=3 in the next cycle. Required: rdata0=0x5, rdata1=0xC, both valid. Both ports at 3 give 0xC/0xC.
3. Bypass, BYPASS=1: entry 2 holds 0x3; wen=1, waddr=2, wdata=0x9, raddr0=2, raddr1=1 in the same cycle. Required: rdata0=0x9, rvalid0=1; rdata1 = old entry 1. With BYPASS=0 the same stimulus gives rdata0=0x3, and 0x9 the next cycle.
4. Clear + write: entries 0..3 written 0x1..0x4; then clear=1, wen=1, waddr=1, wdata=0xF. Required next cycle: entry 1=0xF valid; entries 0, 2, 3 = 0 and invalid.
5. ZERO_REG0=1: write waddr=0, wdata=0x7. Required: rdata0(raddr=0)=0, rvalid0=1, both in the same cycle and the next. Entry 0 is also never bypassed.
6. Scaled config NUM_ENTRIES=32, DATA_WIDTH=32: write the pattern addr*0x01010101 to all 32 entries. Required: both ports read every address back correctly, and entry 31 wraps to no other entry.
